// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter.
// Two producers compete for the single write port of the register array:
// ALU results and returning load data. Load returns are buffered in a
// 2-entry FIFO and always win over the ALU.
// A busy scoreboard marks registers that still wait for a load:
//   - issuing a load sets the busy bit of its destination;
//   - the load's writeback clears that bit again.
// Register index 0 is hard-wired: it is never written and never marked busy.
module wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN:0]   alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN:0]   mem_data,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic [XLEN:0]   G,
   output logic [XLEN-1:0] R_in,
   output logic [XLEN-1:0] busy
);

   // Turns a register index into a one-hot enable.
   // Index 0 and indices beyond the array produce an empty mask.
   function automatic logic [XLEN-1:0] rd_decode(input logic [4:0] rd);
      logic [XLEN-1:0] mask;
      mask = '0;
      if ((rd != 5'd0) && (int'(rd) < XLEN)) begin
         mask[rd] = 1'b1;
      end else begin
         mask = '0;
      end
      return mask;
   endfunction

   // FIFO storage: entry 0 is always the head.
   logic [1:0]      count_r;
   logic [4:0]      e0_rd_r;
   logic [XLEN:0]   e0_data_r;
   logic [4:0]      e1_rd_r;
   logic [XLEN:0]   e1_data_r;

   logic            push_s;
   logic            pop_s;
   logic            sel_valid_s;
   logic            sel_mem_s;
   logic [4:0]      sel_rd_s;
   logic [XLEN:0]   sel_data_s;
   logic [XLEN-1:0] clr_mask_s;
   logic [XLEN-1:0] set_mask_s;
   logic [XLEN-1:0] busy_nxt_s;

   // Handshakes depend only on the stored count.
   // A pop in the same cycle therefore never lets an extra load return in.
   assign mem_ready = (count_r < 2'd2);
   assign alu_ready = (count_r == 2'd0);
   assign push_s    = mem_valid & mem_ready;
   assign pop_s     = (count_r != 2'd0);

   // Choose this cycle's write: the queued load first, otherwise the ALU.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_mem_s   = 1'b0;
      sel_rd_s    = 5'd0;
      sel_data_s  = '0;
      if (pop_s) begin
         sel_valid_s = 1'b1;
         sel_mem_s   = 1'b1;
         sel_rd_s    = e0_rd_r;
         sel_data_s  = e0_data_r;
      end else if (alu_valid) begin
         sel_valid_s = 1'b1;
         sel_mem_s   = 1'b0;
         sel_rd_s    = alu_rd;
         sel_data_s  = alu_data;
      end else begin
         sel_valid_s = 1'b0;
         sel_mem_s   = 1'b0;
      end
   end

   // Build the scoreboard clear mask (load writebacks only) and the set mask (load issue).
   always_comb begin
      clr_mask_s = '0;
      set_mask_s = '0;
      if (sel_valid_s && sel_mem_s) begin
         clr_mask_s = rd_decode(sel_rd_s);
      end else begin
         clr_mask_s = '0;
      end
      if (iss_valid) begin
         set_mask_s = rd_decode(iss_rd);
      end else begin
         set_mask_s = '0;
      end
      // The set is applied after the clear, so it wins when both hit the same bit.
      busy_nxt_s    = (busy & ~clr_mask_s) | set_mask_s;
      busy_nxt_s[0] = 1'b0;
   end

   // Load-return FIFO: shift-style two-entry queue.
   // It keeps order when a push and a pop happen together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_r   <= 2'd0;
         e0_rd_r   <= 5'd0;
         e0_data_r <= '0;
         e1_rd_r   <= 5'd0;
         e1_data_r <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  e0_rd_r   <= mem_rd;
                  e0_data_r <= mem_data;
               end else begin
                  e1_rd_r   <= mem_rd;
                  e1_data_r <= mem_data;
               end
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               e0_rd_r   <= e1_rd_r;
               e0_data_r <= e1_data_r;
               count_r   <= count_r - 2'd1;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  e0_rd_r   <= mem_rd;
                  e0_data_r <= mem_data;
               end else begin
                  e0_rd_r   <= e1_rd_r;
                  e0_data_r <= e1_data_r;
                  e1_rd_r   <= mem_rd;
                  e1_data_r <= mem_data;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Register-array write port: one-cycle enable pulse, data held between writes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         G    <= '0;
         R_in <= '0;
      end else if (sel_valid_s) begin
         G    <= sel_data_s;
         R_in <= rd_decode(sel_rd_s);
      end else begin
         R_in <= '0;
      end
   end

   // Outstanding-load scoreboard.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt_s;
      end
   end

endmodule
